// File: rtl/bk_iopage_ctl.sv
// I/O page register block: bus reply/timeout FSM, roll/mask/sysreg registers
// and a vectored interrupt controller for NCHAN level-sensitive requests.
module bk_iopage_ctl #(
   parameter int                 NCHAN      = 2,
   parameter logic [8*NCHAN-1:0] VECTORS    = {8'o274, 8'o060},
   parameter int                 REPLY_WAIT = 1,
   parameter int                 TIMEOUT    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic [15:0]      addr_i,
   input  logic [15:0]      data_i,
   input  logic             wtbt_i,
   input  logic             din_i,
   input  logic             dout_i,
   input  logic             iako_i,
   input  logic [2:0]       psw_pri_i,
   input  logic             mem_reply_i,
   input  logic [NCHAN-1:0] irq_req_i,
   input  logic [15:0]      ext_data_i,
   input  logic [15:0]      usr_i,
   input  logic [7:0]       sys_i,
   output logic [15:0]      data_o,
   output logic             rply_o,
   output logic             error_o,
   output logic             virq_o,
   output logic [NCHAN-1:0] ack_o,
   output logic [15:0]      roll_o,
   output logic [7:0]       sys_o,
   output logic             ext_rd_o
);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REPLY, S_ERR, S_TOUT} state_t;

   localparam logic [6:0]  OFF_CSR  = 7'o060;
   localparam logic [6:0]  OFF_EXT  = 7'o062;
   localparam logic [6:0]  OFF_ROLL = 7'o064;
   localparam logic [6:0]  OFF_MASK = 7'o070;
   localparam logic [6:0]  OFF_PEND = 7'o072;
   localparam logic [6:0]  OFF_USR  = 7'o114;
   localparam logic [6:0]  OFF_SYS  = 7'o116;
   localparam logic [15:0] ROLL_WR  = 16'o001377;
   localparam logic [15:0] ROLL_RST = 16'o001330;
   localparam logic [7:0]  RW8      = 8'(REPLY_WAIT);
   localparam logic [7:0]  TO8      = 8'(TIMEOUT);

   state_t                 state, state_nxt;
   logic [7:0]             cnt;
   logic                   sync, sync_q, sync_rise, mem_seen;
   logic                   reg_sp, off_ok, rom_wr, commit;
   logic                   be_lo, be_hi, iak, iak_q;
   logic [6:0]             off;
   logic [15:0]            roll, reg_rd, wmask;
   logic [NCHAN-1:0]       mask, pend, ack_sel;
   logic [NCHAN-1:0][7:0]  vec_tab;
   logic [7:0]             vec_sel;

   assign sync      = din_i | dout_i;
   assign sync_rise = sync & ~sync_q;
   assign iak       = iako_i & din_i;
   assign reg_sp    = (addr_i[15:7] == 9'o777);
   assign rom_wr    = dout_i & addr_i[15];
   assign off       = {addr_i[6:1], 1'b0};
   assign off_ok    = off inside {OFF_CSR, OFF_EXT, OFF_ROLL, OFF_MASK, OFF_PEND, OFF_USR, OFF_SYS};
   assign be_lo     = ~wtbt_i | ~addr_i[0];
   assign be_hi     = ~wtbt_i | addr_i[0];
   assign wmask     = {{8{be_hi}}, {8{be_lo}}} & ROLL_WR;
   assign pend      = irq_req_i & ~mask;
   assign vec_tab   = VECTORS;
   assign virq_o    = (|pend) & (psw_pri_i == 3'd0);
   assign roll_o    = roll;

   // State register
   always_ff @(posedge clk or posedge reset)
      if (reset)   state <= S_IDLE;
      else if (ce) state <= state_nxt;

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (sync_rise) begin
               if (reg_sp)      state_nxt = !off_ok ? S_ERR : (REPLY_WAIT == 0) ? S_REPLY : S_WAIT;
               else if (rom_wr) state_nxt = S_ERR;
               else             state_nxt = S_TOUT;
            end
         S_WAIT:
            if (!sync)                    state_nxt = S_IDLE;
            else if (cnt + 8'd1 >= RW8)   state_nxt = S_REPLY;
         S_REPLY, S_ERR:
            if (!sync) state_nxt = S_IDLE;
         S_TOUT:
            if (!sync) state_nxt = S_IDLE;
            else if (!mem_seen && !mem_reply_i && (cnt + 8'd1 >= TO8)) state_nxt = S_ERR;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs; a register cycle commits exactly once, on entry to REPLY
   always_comb begin
      rply_o  = (state == S_REPLY);
      error_o = (state == S_ERR);
      commit  = ce && (state != S_REPLY) && (state_nxt == S_REPLY);
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt      <= '0;
         mem_seen <= 1'b0;
      end else if (ce) begin
         cnt      <= (state == S_WAIT || state == S_TOUT) ? cnt + 8'd1 : 8'd0;
         mem_seen <= (state == S_TOUT) & (mem_seen | mem_reply_i);
      end

   // sync_q resets high so a strobe still held across reset is not taken as a new cycle
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sync_q   <= 1'b1;
         iak_q    <= 1'b0;
         mask     <= '0;
         roll     <= ROLL_RST;
         sys_o    <= '0;
         ext_rd_o <= 1'b0;
         ack_o    <= '0;
      end else if (ce) begin
         sync_q   <= sync;
         iak_q    <= iak;
         ext_rd_o <= commit && din_i && (off == OFF_EXT);
         ack_o    <= (iak && !iak_q) ? ack_sel : '0;
         if (commit && dout_i)
            case (off)
               OFF_CSR:  if (be_lo) mask[0] <= data_i[6];
               OFF_ROLL: roll <= (roll & ~wmask) | (data_i & wmask);
               OFF_MASK: if (be_lo) mask <= data_i[NCHAN-1:0];
               OFF_SYS:  if (be_lo) sys_o <= data_i[7:0];
               default: ;
            endcase
      end

   always_comb begin
      reg_rd = '0;
      case (off)
         OFF_CSR:  reg_rd = {8'h00, irq_req_i[0], mask[0], 6'b000000};
         OFF_EXT:  reg_rd = ext_data_i;
         OFF_ROLL: reg_rd = roll;
         OFF_MASK: reg_rd = 16'(mask);
         OFF_PEND: reg_rd = 16'(pend);
         OFF_USR:  reg_rd = usr_i;
         OFF_SYS:  reg_rd = {8'o200, sys_i};
         default:  reg_rd = '0;
      endcase
   end

   // Lowest pending channel wins; with nothing pending, channel 0's vector is returned
   always_comb begin
      vec_sel = vec_tab[0];
      ack_sel = '0;
      for (int i = NCHAN - 1; i >= 0; i--)
         if (pend[i]) begin
            vec_sel    = vec_tab[i];
            ack_sel    = '0;
            ack_sel[i] = 1'b1;
         end
   end

   assign data_o = iako_i ? {8'h00, vec_sel} : reg_sp ? reg_rd : 16'o177777;

endmodule
